// File: rtl/mu0_control_fsm.sv
// MU0 sequencing controller.
// Runs the two-phase fetch/execute cycle. It decodes the opcode held in IR[15:12]
// and drives every datapath enable, mux select, ALU function and memory strobe.
// The state register and the retired-instruction counter are clocked.
// The control outputs are decoded from the current state in the same cycle, and
// they also depend on the inputs of that same cycle: IR_En and PC_En in FETCH,
// and every memory-gated enable in EXEC, follow MemRdy directly.
// An access that is not yet complete simply holds its outputs until MemRdy rises.
//
// Memory handshake: a read (Rd) or write (Wr) strobe is held high until the
// cycle in which MemRdy=1. That cycle completes the access. Any register load
// that depends on the access happens on the clock edge that ends that cycle.
// The controller never drives Rd and Wr in the same cycle.
//
// State is exported on State for observation (FETCH=0, EXEC=1, HALT=2).
module mu0_control_fsm #(
  parameter int OPW   = 4,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [OPW-1:0]   Opcode,
  input  logic             N_flag,
  input  logic             Z_flag,
  input  logic             MemRdy,
  output logic             IR_En,
  output logic             PC_En,
  output logic             ACC_En,
  output logic             Addr_sel,
  output logic             X_sel,
  output logic             Y_sel,
  output logic [1:0]       ALU_fs,
  output logic             Rd,
  output logic             Wr,
  output logic             Halted,
  output logic [CNT_W-1:0] InstrCnt,
  output logic [1:0]       State
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [OPW-1:0] OP_LDA = OPW'(0);
  localparam logic [OPW-1:0] OP_STA = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3);
  localparam logic [OPW-1:0] OP_JMP = OPW'(4);
  localparam logic [OPW-1:0] OP_JGE = OPW'(5);
  localparam logic [OPW-1:0] OP_JNE = OPW'(6);
  localparam logic [OPW-1:0] OP_STP = OPW'(7);

  localparam logic [1:0] FS_Y    = 2'b00;
  localparam logic [1:0] FS_ADD  = 2'b01;
  localparam logic [1:0] FS_INC  = 2'b10;
  localparam logic [1:0] FS_SUB  = 2'b11;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic       ir_en_c, pc_en_c, acc_en_c;
  logic       addr_sel_c, x_sel_c, y_sel_c;
  logic [1:0] alu_fs_c;
  logic       rd_c, wr_c;
  logic       exec_done_c;

  // Decode state, opcode and handshake into datapath controls and next state.
  always_comb begin
    state_d     = state_q;
    ir_en_c     = 1'b0;
    pc_en_c     = 1'b0;
    acc_en_c    = 1'b0;
    addr_sel_c  = 1'b0;
    x_sel_c     = 1'b0;
    y_sel_c     = 1'b0;
    alu_fs_c    = FS_Y;
    rd_c        = 1'b0;
    wr_c        = 1'b0;
    exec_done_c = 1'b0;
    case (state_q)
      FETCH: begin
        // Read the instruction at PC; in the same cycle, PC+1 goes back into PC.
        rd_c     = 1'b1;
        x_sel_c  = 1'b1;
        alu_fs_c = FS_INC;
        ir_en_c  = MemRdy;
        pc_en_c  = MemRdy;
        if (MemRdy) state_d = EXEC;
      end
      EXEC: begin
        addr_sel_c = 1'b1;
        case (Opcode)
          OP_LDA: begin
            rd_c        = 1'b1;
            alu_fs_c    = FS_Y;
            acc_en_c    = MemRdy;
            exec_done_c = MemRdy;
          end
          OP_STA: begin
            wr_c        = 1'b1;
            exec_done_c = MemRdy;
          end
          OP_ADD: begin
            rd_c        = 1'b1;
            alu_fs_c    = FS_ADD;
            acc_en_c    = MemRdy;
            exec_done_c = MemRdy;
          end
          OP_SUB: begin
            rd_c        = 1'b1;
            alu_fs_c    = FS_SUB;
            acc_en_c    = MemRdy;
            exec_done_c = MemRdy;
          end
          OP_JMP: begin
            y_sel_c     = 1'b1;
            pc_en_c     = 1'b1;
            exec_done_c = 1'b1;
          end
          OP_JGE: begin
            y_sel_c     = 1'b1;
            pc_en_c     = ~N_flag;
            exec_done_c = 1'b1;
          end
          OP_JNE: begin
            y_sel_c     = 1'b1;
            pc_en_c     = ~Z_flag;
            exec_done_c = 1'b1;
          end
          default: begin
            // STP and the unassigned opcodes retire in one cycle with no side effects.
            exec_done_c = 1'b1;
          end
        endcase
        if (exec_done_c) state_d = (Opcode == OP_STP) ? HALT : FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // State register and saturating retired-instruction counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == EXEC && exec_done_c && cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // While Reset is high, the strobes are forced low. This kills an in-flight
  // access immediately, without waiting for the next clock edge.
  assign IR_En    = ~Reset & ir_en_c;
  assign PC_En    = ~Reset & pc_en_c;
  assign ACC_En   = ~Reset & acc_en_c;
  assign Addr_sel = ~Reset & addr_sel_c;
  assign X_sel    = ~Reset & x_sel_c;
  assign Y_sel    = ~Reset & y_sel_c;
  assign ALU_fs   = Reset ? 2'b00 : alu_fs_c;
  assign Rd       = ~Reset & rd_c;
  assign Wr       = ~Reset & wr_c;
  assign Halted   = ~Reset & (state_q == HALT);
  assign InstrCnt = cnt_q;
  assign State    = state_q;

endmodule
